// File: rtl/reshuffle_pkg.sv
// Shared definitions for the PosT row-rotation reshuffle and its inverse.
package reshuffle_pkg;

    // Depth of the output skid buffer between the restore stage and the consumer.
    localparam int FIFO_DEPTH = 2;

    // Source row for output row r. Forward: (r+step)%n. Inverse: (r+n-step)%n.
    function automatic int rot_src_idx(int r, int step, int n, bit inverse);
        if (inverse)
            return (r + n - step) % n;
        else
            return (r + step) % n;
    endfunction

    // Width of a step field for an n-row patch. Never narrower than 1 bit.
    function automatic int step_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reshuffle_restore_stage_fifo.sv
// Two-entry pointer/count buffer holding restored patches with their step and sof tags.
module patch_skid_fifo
    import reshuffle_pkg::*;
#(
    parameter int N      = 4,
    parameter int WIDTH  = 32,
    parameter int STEP_W = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  push_valid,
    output logic                                  push_ready,
    input  logic signed [N-1:0][N-1:0][WIDTH-1:0] push_patch,
    input  logic        [STEP_W-1:0]              push_step,
    input  logic                                  push_sof,
    input  logic                                  pop_ready,
    output logic                                  pop_valid,
    output logic signed [N-1:0][N-1:0][WIDTH-1:0] pop_patch,
    output logic        [STEP_W-1:0]              pop_step,
    output logic                                  pop_sof
);

    logic signed [1:0][N-1:0][N-1:0][WIDTH-1:0] mem_patch;
    logic        [1:0][STEP_W-1:0]              mem_step;
    logic        [1:0]                          mem_sof;
    logic                                       wr_ptr;
    logic                                       rd_ptr;
    logic        [1:0]                          count;
    logic                                       push;
    logic                                       pop;

    // Ready depends only on registered occupancy, never on pop_ready.
    assign push_ready = !rst && (count < 2'(FIFO_DEPTH));
    assign push       = push_valid && push_ready;
    assign pop        = pop_ready && (count != 2'd0);

    assign pop_valid  = (count != 2'd0);
    assign pop_patch  = mem_patch[rd_ptr];
    assign pop_step   = mem_step[rd_ptr];
    assign pop_sof    = mem_sof[rd_ptr];

    // Entry storage: written at the write pointer on every accepted push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_patch <= '0;
            mem_step  <= '0;
            mem_sof   <= '0;
        end else if (push) begin
            mem_patch[wr_ptr] <= push_patch;
            mem_step[wr_ptr]  <= push_step;
            mem_sof[wr_ptr]   <= push_sof;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reshuffle_restore_stage.sv
// Undoes the producer's row rotation and hands restored patches to the output-buffer reader.
module reshuffle_restore_stage
    import reshuffle_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_sof,
    input  logic signed [N-1:0][N-1:0][WIDTH-1:0] in_patch,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [N-1:0][N-1:0][WIDTH-1:0] out_patch,
    output logic        [step_width(N)-1:0]       out_step,
    output logic                                  out_sof
);

    localparam int                STEP_W    = step_width(N);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N - 1);

    logic        [STEP_W-1:0]              step_q;
    logic        [STEP_W-1:0]              step_use;
    logic signed [N-1:0][N-1:0][WIDTH-1:0] rest;
    logic                                  push;

    // A start-of-frame patch always uses step 0, even mid-sequence.
    assign step_use = in_sof ? '0 : step_q;
    assign push     = in_valid && in_ready;

    // Rotation step tracker, advanced once per accepted patch with explicit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_q <= '0;
        else if (push)
            step_q <= (step_use == STEP_LAST) ? '0 : step_use + 1'b1;
    end

    // Row selection: output row r takes input row (r+N-step)%N, values untouched.
    for (genvar r = 0; r < N; r++) begin : g_row
        logic [N-1:0][WIDTH-1:0] row_sel;

        // One N-way row mux per output row, keyed on the current step.
        always_comb begin
            row_sel = in_patch[r];
            for (int s = 1; s < N; s++) begin
                if (step_use == STEP_W'(s))
                    row_sel = in_patch[rot_src_idx(r, s, N, 1'b1)];
            end
        end

        assign rest[r] = row_sel;
    end

    patch_skid_fifo #(
        .N      (N),
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (in_valid),
        .push_ready (in_ready),
        .push_patch (rest),
        .push_step  (step_use),
        .push_sof   (in_sof),
        .pop_ready  (out_ready),
        .pop_valid  (out_valid),
        .pop_patch  (out_patch),
        .pop_step   (out_step),
        .pop_sof    (out_sof)
    );

endmodule

// File: tb/tb_reshuffle_restore_stage.sv
// Scoreboard bench for reshuffle_restore_stage: an N=4 and an N=3 instance, both 8-bit elements.
module tb_reshuffle_restore_stage;

    typedef logic [3:0][3:0][7:0] p4_t;
    typedef logic [2:0][2:0][7:0] p3_t;
    typedef struct { p4_t p; logic [1:0] s; logic sof; int acc; bit lat; } e4_t;
    typedef struct { p3_t p; logic [1:0] s; logic sof; } e3_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       a_in_valid = 1'b0, a_in_sof = 1'b0, a_out_ready = 1'b0;
    p4_t        a_in_patch = '0;
    logic       a_in_ready, a_out_valid, a_out_sof;
    p4_t        a_out_patch;
    logic [1:0] a_out_step;

    logic       b_in_valid = 1'b0, b_in_sof = 1'b0, b_out_ready = 1'b0;
    p3_t        b_in_patch = '0;
    logic       b_in_ready, b_out_valid, b_out_sof;
    p3_t        b_out_patch;
    logic [1:0] b_out_step;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    e4_t  qa[$];
    e3_t  qb[$];
    logic [1:0] a_step_m = 2'd0;
    logic [1:0] b_step_m = 2'd0;
    bit   rand_on = 1'b0;

    reshuffle_restore_stage #(.N(4), .WIDTH(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sof(a_in_sof), .in_patch(a_in_patch),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_patch(a_out_patch),
        .out_step(a_out_step), .out_sof(a_out_sof)
    );

    reshuffle_restore_stage #(.N(3), .WIDTH(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof), .in_patch(b_in_patch),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_patch(b_out_patch),
        .out_step(b_out_step), .out_sof(b_out_sof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Producer-side reshuffle: out[r][c] = in[(r+s)%N][c]
    function automatic p4_t fwd4(p4_t p, int s);
        p4_t o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[r][c] = p[(r + s) % 4][c];
        return o;
    endfunction

    function automatic p3_t fwd3(p3_t p, int s);
        p3_t o;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                o[r][c] = p[(r + s) % 3][c];
        return o;
    endfunction

    function automatic p4_t pat(int base);
        p4_t p;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                p[r][c] = 8'(base + r * 4 + c);
        return p;
    endfunction

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_a(p4_t p, logic sof, bit lat);
        logic [1:0] s;
        int n;
        s = sof ? 2'd0 : a_step_m;
        a_in_valid = 1'b1;
        a_in_sof   = sof;
        a_in_patch = fwd4(p, s);
        n = 0;
        while (!a_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("a_accept_timeout", 1, 0);
        end else begin
            qa.push_back('{p, s, sof, cyc, lat});
            a_step_m = s + 2'd1;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        a_in_sof   = 1'b0;
    endtask

    task automatic send_b(p3_t p, logic sof);
        logic [1:0] s;
        int n;
        s = sof ? 2'd0 : b_step_m;
        b_in_valid = 1'b1;
        b_in_sof   = sof;
        b_in_patch = fwd3(p, s);
        n = 0;
        while (!b_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("b_accept_timeout", 1, 0);
        end else begin
            qb.push_back('{p, s, sof});
            b_step_m = (s == 2'd2) ? 2'd0 : s + 2'd1;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        b_in_sof   = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_drain_left", qa.size(), 0);
        chk("b_drain_left", qb.size(), 0);
    endtask

    task automatic rand_a(int count);
        p4_t p;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    p[r][c] = 8'($urandom);
            if (i == 0) p[0][0] = 8'h80;
            send_a(p, (i == 0) || ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    task automatic rand_b(int count);
        p3_t p;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    p[r][c] = 8'($urandom);
            if (i == 0) p[2][2] = 8'hff;
            send_b(p, (i == 0) || ($urandom_range(0, 7) == 0));
        end
    endtask

    // Monitor for the N=4 instance
    always @(negedge clk) begin : mon_a
        e4_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_out", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_patch", a_out_patch, e.p);
                chk("a_step", a_out_step, e.s);
                chk("a_sof", a_out_sof, e.sof);
                if (e.lat) chk("a_latency", cyc - e.acc, 1);
            end
        end
    end

    // Monitor for the N=3 instance
    always @(negedge clk) begin : mon_b
        e3_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_out", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_patch", b_out_patch, e.p);
                chk("b_step", b_out_step, e.s);
                chk("b_sof", b_out_sof, e.sof);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        p4_t p;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_patch", a_out_patch, 0);
        chk("rst_out_step", a_out_step, 0);
        chk("rst_out_sof", a_out_sof, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", a_in_ready, 1);
        chk("b_in_ready_after_rst", b_in_ready, 1);
        repeat (2) @(negedge clk);
        chk("empty_pop_out_valid", a_out_valid, 0);
        chk("empty_pop_in_ready", a_in_ready, 1);

        // Back-to-back patches, row r of patch k = k*10+r, steps 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    p[r][c] = 8'(k * 10 + r);
            send_a(p, k == 0, 1'b1);
        end
        drain();

        // Consumer stall: two accepted, third held, head stable
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        @(negedge clk);
        send_a(pat(50), 1'b1, 1'b0);
        send_a(pat(60), 1'b0, 1'b0);
        fork
            send_a(pat(70), 1'b0, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    chk("stall_in_ready", a_in_ready, 0);
                    chk("stall_out_valid", a_out_valid, 1);
                    chk("stall_out_patch", a_out_patch, pat(50));
                    chk("stall_out_step", a_out_step, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 a_out_ready = 1'b1;
            end
        join
        drain();

        // sof on the third patch restarts the step: 0,1,0,1
        send_a(pat(80), 1'b1, 1'b0);
        send_a(pat(90), 1'b0, 1'b0);
        send_a(pat(100), 1'b1, 1'b0);
        send_a(pat(110), 1'b0, 1'b0);
        drain();

        // Reset with two entries buffered
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        @(negedge clk);
        send_a(pat(120), 1'b1, 1'b0);
        send_a(pat(130), 1'b0, 1'b0);
        chk("full_in_ready", a_in_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", a_out_valid, 0);
        chk("async_rst_in_ready", a_in_ready, 0);
        chk("async_rst_out_patch", a_out_patch, 0);
        qa.delete();
        a_step_m = 2'd0;
        b_step_m = 2'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        send_a(pat(140), 1'b0, 1'b1);
        drain();

        // Random traffic on both sizes, signed 8-bit data
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom_range(0, 1));
                    b_out_ready = 1'($urandom_range(0, 1));
                end
            end
            begin
                fork
                    rand_a(500);
                    rand_b(500);
                join
                rand_on = 1'b0;
            end
        join
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(negedge clk);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
